// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit signed ALU and its round-robin scheduler.
package alu_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned DAT_W = 4;
  localparam int unsigned RES_W = 5;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_NOT = 3'b010;
  localparam logic [OP_W-1:0] OP_AND = 3'b011;
  localparam logic [OP_W-1:0] OP_OR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR = 3'b101;
  localparam logic [OP_W-1:0] OP_LT  = 3'b110;
  localparam logic [OP_W-1:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [DAT_W-1:0] a;
    logic [DAT_W-1:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu4_core.sv
// Combinational 4-bit signed ALU: op/A/B -> 5-bit result and compare flag.
module alu4_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [DAT_W-1:0] a,
  input  logic [DAT_W-1:0] b,
  output logic [RES_W-1:0] result,
  output logic             flag
);

  logic [RES_W-1:0] a_x;
  logic [RES_W-1:0] b_x;

  always_comb begin
    a_x    = {a[DAT_W-1], a};
    b_x    = {b[DAT_W-1], b};
    result = '0;
    flag   = 1'b0;
    case (op)
      OP_ADD:  result = a_x + b_x;
      OP_SUB:  result = a_x - b_x;
      OP_NOT:  result = {1'b0, ~a};
      OP_AND:  result = {1'b0, a & b};
      OP_OR:   result = {1'b0, a | b};
      OP_XOR:  result = {1'b0, a ^ b};
      OP_LT:   flag   = ($signed(a) < $signed(b));
      OP_EQ:   flag   = (a == b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one registered ALU stage between NREQ requesters.
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [OP_W*NREQ-1:0]   req_op,
  input  logic [DAT_W*NREQ-1:0]  req_a,
  input  logic [DAT_W*NREQ-1:0]  req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [RES_W-1:0]       rsp_result,
  output logic                   rsp_flag,
  output logic                   busy
);

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   ptr_nxt;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cap_id;
  logic             win_found;
  alu_req_t         win_req;
  alu_req_t         cap_req;
  logic [RES_W-1:0] alu_result;
  logic             alu_flag;

  // Winner search: first pass from rr_ptr upward, second pass wraps to the bottom.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!win_found && req_valid[i] && (IDW'(i) >= rr_ptr)) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!win_found && req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
    win_req = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win_idx) begin
        win_req.op = req_op[OP_W*i +: OP_W];
        win_req.a  = req_a[DAT_W*i +: DAT_W];
        win_req.b  = req_b[DAT_W*i +: DAT_W];
      end
    end
    ptr_nxt = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (win_found) state_nxt = EXEC;
        for (int unsigned i = 0; i < NREQ; i++) begin
          req_ready[i] = !rst && win_found && (IDW'(i) == win_idx);
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // Capture on grant, register the ALU output during EXEC; held through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      cap_req    <= '0;
      cap_id     <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flag   <= 1'b0;
    end else begin
      if (state == IDLE && win_found) begin
        cap_req <= win_req;
        cap_id  <= win_idx;
        rr_ptr  <= ptr_nxt;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_flag   <= alu_flag;
        rsp_id     <= cap_id;
      end
    end
  end

  alu4_core u_alu (
    .op     (cap_req.op),
    .a      (cap_req.a),
    .b      (cap_req.b),
    .result (alu_result),
    .flag   (alu_flag)
  );

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched with two requesters and hand-computed results.
module tb_alu_rr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] v;
  logic [1:0] req_ready;
  logic [2:0] op0, op1;
  logic [3:0] a0, a1, b0, b1;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_id;
  logic [4:0] rsp_result;
  logic       rsp_flag;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_rr_sched #(.NREQ(2), .IDW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (v),
    .req_ready  (req_ready),
    .req_op     ({op1, op0}),
    .req_a      ({a1, a0}),
    .req_b      ({b1, b0}),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flag   (rsp_flag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1));
  endtask

  // Single request on one requester, checked end to end.
  task automatic run_op(input int idx, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [4:0] er, input logic ef,
                        input string tag);
    int n = 0;
    logic [1:0] want;
    if (idx == 0) begin
      op0 = op; a0 = a; b0 = b; want = 2'b01;
    end else begin
      op1 = op; a1 = a; b1 = b; want = 2'b10;
    end
    v = want;
    #1;
    while (req_ready !== want && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_grant"}, 32'(req_ready), 32'(want));
    tick();
    v = 2'b00;
    wait_rsp(tag);
    chk({tag, "_id"}, 32'(rsp_id), 32'(idx));
    chk({tag, "_result"}, 32'(rsp_result), 32'(er));
    chk({tag, "_flag"}, 32'(rsp_flag), 32'(ef));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [1:0] last_id;
    rst = 1'b1; v = 2'b00; rsp_ready = 1'b0;
    op0 = '0; op1 = '0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("rst_rsp_result", 32'(rsp_result), 32'(0));
    chk("rst_rsp_flag", 32'(rsp_flag), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    tick();

    // Single request: -2 + 1 = -1
    op0 = 3'b000; a0 = 4'b1110; b0 = 4'b0001; v = 2'b01;
    #1;
    chk("single_grant", 32'(req_ready), 32'(2'b01));
    chk("single_busy_idle", 32'(busy), 32'(0));
    tick();
    v = 2'b00;
    #1;
    chk("single_ready_exec", 32'(req_ready), 32'(0));
    chk("single_busy_exec", 32'(busy), 32'(1));
    chk("single_valid_exec", 32'(rsp_valid), 32'(0));
    tick();
    chk("single_valid", 32'(rsp_valid), 32'(1));
    chk("single_id", 32'(rsp_id), 32'(0));
    chk("single_result", 32'(rsp_result), 32'(5'b11111));
    chk("single_flag", 32'(rsp_flag), 32'(0));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("single_done_valid", 32'(rsp_valid), 32'(0));
    chk("single_done_busy", 32'(busy), 32'(0));

    // Backpressure: req0 ADD 3+4 in flight, req1 XOR waits
    op0 = 3'b000; a0 = 4'd3; b0 = 4'd4; v = 2'b01;
    #1;
    chk("bp_grant0", 32'(req_ready), 32'(2'b01));
    tick();
    op1 = 3'b101; a1 = 4'b1010; b1 = 4'b0110; v = 2'b11;
    #1;
    chk("bp_ready_exec", 32'(req_ready), 32'(0));
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'(1));
      chk("bp_result", 32'(rsp_result), 32'(5'b00111));
      chk("bp_id", 32'(rsp_id), 32'(0));
      chk("bp_ready_hold", 32'(req_ready), 32'(0));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_grant1", 32'(req_ready), 32'(2'b10));
    tick();
    v = 2'b00;
    tick();
    chk("bp_r1_valid", 32'(rsp_valid), 32'(1));
    chk("bp_r1_id", 32'(rsp_id), 32'(1));
    chk("bp_r1_result", 32'(rsp_result), 32'(5'b01100));
    tick();
    rsp_ready = 1'b0;

    // Operation table
    run_op(0, 3'b010, 4'b1010, 4'b0110, 5'b00101, 1'b0, "not");
    run_op(0, 3'b011, 4'b1010, 4'b0110, 5'b00010, 1'b0, "and");
    run_op(1, 3'b100, 4'b1010, 4'b0110, 5'b01110, 1'b0, "or");
    run_op(1, 3'b101, 4'b1010, 4'b0110, 5'b01100, 1'b0, "xor");
    run_op(0, 3'b111, 4'b1000, 4'b1000, 5'b00000, 1'b1, "eq");
    run_op(1, 3'b111, 4'b1000, 4'b0111, 5'b00000, 1'b0, "neq");
    run_op(0, 3'b110, 4'b0111, 4'b1000, 5'b00000, 1'b0, "lt_false");
    run_op(1, 3'b001, 4'b1000, 4'b0111, 5'b10001, 1'b0, "sub_min");
    run_op(0, 3'b000, 4'b1000, 4'b1000, 5'b10000, 1'b0, "add_min");

    // Fairness from a fresh reset: grants alternate 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    op0 = 3'b001; a0 = 4'd3; b0 = 4'd5;
    op1 = 3'b110; a1 = 4'b1000; b1 = 4'b0111;
    rsp_ready = 1'b1;
    v = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_rsp("fair");
      chk("fair_id", 32'(rsp_id), 32'(k % 2));
      chk("fair_result", 32'(rsp_result), (k % 2 == 0) ? 32'(5'b11110) : 32'(0));
      chk("fair_flag", 32'(rsp_flag), (k % 2 == 0) ? 32'(0) : 32'(1));
      tick();
    end
    v = 2'b00;
    cnt = 0;
    while (busy !== 1'b0 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("fair_drain", 32'(busy), 32'(0));

    // Reset during EXEC; rr pointer moved to 1 beforehand
    v = 2'b01;
    tick();
    v = 2'b11;
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'(0));
    chk("mid_rst_valid", 32'(rsp_valid), 32'(0));
    chk("mid_rst_id", 32'(rsp_id), 32'(0));
    chk("mid_rst_result", 32'(rsp_result), 32'(0));
    chk("mid_rst_flag", 32'(rsp_flag), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    v = 2'b00;
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid === 1'b1 || busy === 1'b1) cnt++;
    end
    chk("post_rst_quiet", 32'(cnt), 32'(0));
    v = 2'b11;
    #1;
    chk("post_rst_ptr", 32'(req_ready), 32'(2'b01));
    tick();
    v = 2'b00;
    wait_rsp("post_rst");
    chk("post_rst_id", 32'(rsp_id), 32'(0));
    chk("post_rst_result", 32'(rsp_result), 32'(5'b11110));
    tick();

    // Idle, then a one-cycle request from req1
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy !== 1'b0 || req_ready !== 2'b00) cnt++;
    end
    chk("idle_quiet", 32'(cnt), 32'(0));
    op1 = 3'b000; a1 = 4'd1; b1 = 4'd2;
    v = 2'b10;
    #1;
    chk("pulse_grant", 32'(req_ready), 32'(2'b10));
    tick();
    v = 2'b00;
    cnt = 0;
    last_id = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid === 1'b1) begin
        cnt++;
        last_id = rsp_id;
      end
    end
    chk("pulse_count", 32'(cnt), 32'(1));
    chk("pulse_id", 32'(last_id), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
